snn_output_collector: RTL and testbench
=======================================

Name: snn_output_collector

Overview:
- Reader-side counterpart of the SNN core's output packet FIFO (packet_out / packet_out_rinc / packet_out_rempty).
- After each tick, waits for the core to finish the tick, then drains all output packets and builds the NUM_OUTPUT-bit spike vector.
- Accumulates per-class votes and reports the winning class to the SoC with a one-cycle result strobe.
- Sits between the SNN wrapper's output FIFO and the CSR/readout logic.

Parameters:
NUM_OUTPUT, 250, number of output neurons; valid packet index range is 0..NUM_OUTPUT-1
NUM_CLASSES, 10, number of classes
NEURONS_PER_CLASS, 25, neurons per class; class = idx / NEURONS_PER_CLASS; NUM_CLASSES*NEURONS_PER_CLASS == NUM_OUTPUT
WAIT_CYCLES, 70000, cycles to wait after tick before draining
WAIT_WIDTH, 17, width of the wait counter

Ports:
clk  in  1  clock; single domain, same clock as the FIFO read side
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse marking the start of a new frame
packet_out  in  8  FIFO head data; first-word fall-through, valid whenever packet_out_rempty=0
packet_out_rempty  in  1  FIFO empty flag
packet_out_rinc  out  1  FIFO pop strobe, one cycle per packet
spike_vec  out  NUM_OUTPUT  spike vector; bit [NUM_OUTPUT-1-idx] set for neuron idx
result_valid  out  1  one-cycle strobe; result outputs are stable from this cycle until the next tick
result_class  out  4  winning class index
result_count  out  8  number of distinct spiking neurons in the frame
range_error  out  1  sticky; set when packet_out >= NUM_OUTPUT; cleared only by reset
busy  out  1  high in every state other than IDLE and DONE

Behaviour:
- Reset (clk edge with reset=1) puts the block in state IDLE with all outputs 0: spike_vec, class vote counters, wait counter, result_*, rinc, range_error.
- States: IDLE, WAIT, POP, GAP, SCAN, DONE.
- Tick in any state, including mid-drain or mid-scan:
  - next state is WAIT; the wait counter loads WAIT_CYCLES-1;
  - spike_vec, votes and result_count clear;
  - result_valid is deasserted;
  - result_class holds its value until the next strobe.
  - Tick has priority over every other transition.
- WAIT: counter decrements each cycle; at 0 go to POP.
- POP:
  - If rempty=0: drive rinc=1 for this cycle, sample packet_out, go to GAP.
  - If rempty=1: go to SCAN; no rinc.
- GAP: rinc=0 for one cycle (allows the FIFO empty flag to update), then back to POP. Maximum pop rate is one packet per 2 cycles; rinc is never asserted while rempty=1.
- Packet processing for sampled idx:
  - idx >= NUM_OUTPUT: drop the packet and set range_error. The pop is still performed.
  - idx valid and bit already set: no change (duplicates are ignored).
  - idx valid and bit clear: set the bit, increment votes[idx / NEURONS_PER_CLASS] (comparison chain, no divider), increment result_count.
- Counter widths: votes are 5 bits, saturating at NEURONS_PER_CLASS; result_count is 8 bits, max 250, no wrap.
- SCAN:
  - One class per cycle, NUM_CLASSES cycles in total.
  - Tracks the running maximum, replacing it only when votes > max; ties therefore go to the lowest index.
  - All-zero votes give class 0.
  - After the last class: go to DONE and pulse result_valid for 1 cycle.
- DONE: hold all outputs until the next tick.
- Latency: for N packets, result_valid rises WAIT_CYCLES + 2N + 1 + NUM_CLASSES cycles after tick. Exact edge counts are set by the state sequence above.
- Packets arriving in the FIFO during WAIT are left untouched until POP.
- An empty FIFO at POP entry goes straight to SCAN with an all-zero result.

Test Plan:
- Reset mid-POP with 5 packets pending -> next cycle all outputs 0, state IDLE, rinc=0, no further pops.
- WAIT_CYCLES=8; tick, FIFO preloaded with 0, 24, 25, 249 -> spike_vec bits 249, 225, 224 and 0 set; votes[0]=2, votes[1]=1, votes[9]=1; result_class=0, result_count=4; result_valid a single pulse at cycle 8+8+1+10 after tick; exactly 4 rinc pulses, each followed by a low cycle.
- Duplicates plus tie: packets 30, 30, 55, 56, 130, 131 -> result_count=5; votes[1]=1, votes[2]=2, votes[5]=2; result_class=2 (lowest-index tie).
- Packet 250 among packets 3, 4 -> range_error=1 and stays 1 across later frames; result_count=2; the bad packet is still popped (3 rinc pulses).
- Empty FIFO after tick -> no rinc, spike_vec=0, result_class=0, result_count=0, result_valid after WAIT_CYCLES+1+10 cycles.
- Second tick during POP of a 10-packet frame -> vector, votes and count clear that cycle; WAIT restarts; the remaining packets are drained in the new frame and only the new frame's result is reported.

Source files
------------

// File: rtl/snn_output_collector.sv
// snn_output_collector
// Drains the SNN core's output packet FIFO after every tick. It rebuilds the
// per-frame spike vector, counts votes per class, and reports the winning class.
//
// Sequence per frame:
//   tick -> WAIT (settle) -> POP/GAP pairs until empty -> SCAN (one class/cycle) -> DONE
//
// Ports:
//   clk               clock, shared with the FIFO read side
//   reset             synchronous active-high reset
//   tick              one-cycle frame start pulse; restarts the sequence from any state
//   packet_out        FIFO head (first-word fall-through), valid while packet_out_rempty=0
//   packet_out_rempty FIFO empty flag
//   packet_out_rinc   FIFO pop strobe, asserted only in POP with a non-empty FIFO
//   spike_vec         bit [NUM_OUTPUT-1-idx] set when neuron idx spiked this frame
//   result_valid      one-cycle strobe when result_class/result_count are final
//   result_class      winning class (lowest index on ties), held until the next strobe
//   result_count      distinct spiking neurons this frame
//   range_error       sticky flag for a packet index >= NUM_OUTPUT
//   busy              high while the frame is still being processed
module snn_output_collector #(
    parameter int NUM_OUTPUT        = 250,
    parameter int NUM_CLASSES       = 10,
    parameter int NEURONS_PER_CLASS = 25,
    parameter int WAIT_CYCLES       = 70000,
    parameter int WAIT_WIDTH        = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [7:0]            packet_out,
    input  logic                  packet_out_rempty,
    output logic                  packet_out_rinc,
    output logic [NUM_OUTPUT-1:0] spike_vec,
    output logic                  result_valid,
    output logic [3:0]            result_class,
    output logic [7:0]            result_count,
    output logic                  range_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_POP  = 3'd2,
        ST_GAP  = 3'd3,
        ST_SCAN = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD  = WAIT_WIDTH'(WAIT_CYCLES - 1);
    localparam logic [7:0]            IDX_LIMIT  = 8'(NUM_OUTPUT);
    localparam logic [7:0]            MAX_IDX    = 8'(NUM_OUTPUT - 1);
    localparam logic [4:0]            VOTE_MAX   = 5'(NEURONS_PER_CLASS);
    localparam logic [3:0]            LAST_CLASS = 4'(NUM_CLASSES - 1);

    // Class of a neuron index as a chain of threshold compares; this avoids a divider.
    function automatic logic [3:0] class_of(input logic [7:0] idx);
        logic [3:0] cls;
        cls = 4'd0;
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if ({24'd0, idx} >= 32'(c * NEURONS_PER_CLASS)) begin
                cls = 4'(c);
            end
        end
        return cls;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    logic [WAIT_WIDTH-1:0]   wait_cnt_r;
    logic [7:0]              pkt_r;
    logic [4:0]              votes_r [NUM_CLASSES];
    logic [3:0]              scan_r;
    logic [3:0]              best_r;
    logic [4:0]              max_r;
    logic [NUM_OUTPUT-1:0]   spike_vec_r;
    logic                    result_valid_r;
    logic [3:0]              result_class_r;
    logic [7:0]              result_count_r;
    logic                    range_error_r;
    logic                    busy_r;
    logic                    rinc_s;
    logic                    pkt_valid_s;
    logic                    pkt_new_s;
    logic [7:0]              bit_idx_s;
    logic [3:0]              pkt_class_s;
    logic                    scan_hit_s;

    // Decode of the sampled packet and the current scan comparison.
    always_comb begin
        pkt_valid_s = (pkt_r < IDX_LIMIT);
        bit_idx_s   = MAX_IDX - pkt_r;
        pkt_class_s = class_of(pkt_r);
        scan_hit_s  = (votes_r[scan_r] > max_r);
        if (pkt_valid_s) begin
            pkt_new_s = ~spike_vec_r[bit_idx_s];
        end else begin
            pkt_new_s = 1'b0;
        end
    end

    // Next-state logic and pop strobe. rinc is suppressed on tick/reset so that no
    // packet is popped while the frame is being restarted.
    always_comb begin
        next_state_s = state_r;
        rinc_s       = 1'b0;
        if (tick) begin
            next_state_s = ST_WAIT;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_IDLE;
                ST_WAIT: begin
                    if (wait_cnt_r == {WAIT_WIDTH{1'b0}}) begin
                        next_state_s = ST_POP;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_POP: begin
                    if (!packet_out_rempty) begin
                        next_state_s = ST_GAP;
                        rinc_s       = ~reset;
                    end else begin
                        next_state_s = ST_SCAN;
                    end
                end
                ST_GAP:  next_state_s = ST_POP;
                ST_SCAN: begin
                    if (scan_r == LAST_CLASS) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SCAN;
                    end
                end
                ST_DONE: next_state_s = ST_DONE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Busy flag, registered from the next state so it lines up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
        end
    end

    // Datapath: wait counter, packet capture/processing, vote scan and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r     <= {WAIT_WIDTH{1'b0}};
            pkt_r          <= 8'd0;
            scan_r         <= 4'd0;
            best_r         <= 4'd0;
            max_r          <= 5'd0;
            spike_vec_r    <= {NUM_OUTPUT{1'b0}};
            result_valid_r <= 1'b0;
            result_class_r <= 4'd0;
            result_count_r <= 8'd0;
            range_error_r  <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                votes_r[c] <= 5'd0;
            end
        end else if (tick) begin
            // result_class deliberately holds until the next strobe.
            wait_cnt_r     <= WAIT_LOAD;
            scan_r         <= 4'd0;
            best_r         <= 4'd0;
            max_r          <= 5'd0;
            spike_vec_r    <= {NUM_OUTPUT{1'b0}};
            result_valid_r <= 1'b0;
            result_count_r <= 8'd0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                votes_r[c] <= 5'd0;
            end
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (wait_cnt_r != {WAIT_WIDTH{1'b0}}) begin
                        wait_cnt_r <= wait_cnt_r - {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_POP: begin
                    if (!packet_out_rempty) begin
                        pkt_r <= packet_out;
                    end else begin
                        scan_r <= 4'd0;
                        best_r <= 4'd0;
                        max_r  <= 5'd0;
                    end
                end
                ST_GAP: begin
                    if (!pkt_valid_s) begin
                        range_error_r <= 1'b1;
                    end else if (pkt_new_s) begin
                        spike_vec_r[bit_idx_s] <= 1'b1;
                        if (votes_r[pkt_class_s] != VOTE_MAX) begin
                            votes_r[pkt_class_s] <= votes_r[pkt_class_s] + 5'd1;
                        end
                        if (result_count_r != IDX_LIMIT) begin
                            result_count_r <= result_count_r + 8'd1;
                        end
                    end
                end
                ST_SCAN: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (scan_hit_s) begin
                        max_r  <= votes_r[scan_r];
                        best_r <= scan_r;
                    end
                    if (scan_r == LAST_CLASS) begin
                        result_class_r <= scan_hit_s ? scan_r : best_r;
                        result_valid_r <= 1'b1;
                    end else begin
                        scan_r <= scan_r + 4'd1;
                    end
                end
                ST_DONE: result_valid_r <= 1'b0;
                default: result_valid_r <= 1'b0;
            endcase
        end
    end

    assign packet_out_rinc = rinc_s;
    assign spike_vec       = spike_vec_r;
    assign result_valid    = result_valid_r;
    assign result_class    = result_class_r;
    assign result_count    = result_count_r;
    assign range_error     = range_error_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_snn_output_collector.sv
module tb_snn_output_collector;

    localparam int W  = 8;
    localparam int NO = 250;
    localparam int NC = 10;
    localparam int NP = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [7:0]    packet_out;
    logic          packet_out_rempty;
    logic          packet_out_rinc;
    logic [NO-1:0] spike_vec;
    logic          result_valid;
    logic [3:0]    result_class;
    logic [7:0]    result_count;
    logic          range_error;
    logic          busy;

    snn_output_collector #(
        .NUM_OUTPUT(NO), .NUM_CLASSES(NC), .NEURONS_PER_CLASS(NP),
        .WAIT_CYCLES(W), .WAIT_WIDTH(17)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .packet_out(packet_out), .packet_out_rempty(packet_out_rempty),
        .packet_out_rinc(packet_out_rinc), .spike_vec(spike_vec),
        .result_valid(result_valid), .result_class(result_class),
        .result_count(result_count), .range_error(range_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge counter.
    always @(posedge clk) edge_n <= edge_n + 1;

    // FIFO model (first-word fall-through).
    logic [7:0] fq[$];
    bit pop_req = 1'b0;

    task automatic fifo_drive();
        if (fq.size() > 0) begin
            packet_out        = fq[0];
            packet_out_rempty = 1'b0;
        end else begin
            packet_out        = 8'd0;
            packet_out_rempty = 1'b1;
        end
    endtask

    // Pop the head shortly after the edge that saw rinc.
    always @(posedge clk) begin
        logic [7:0] popped;
        if (pop_req) begin
            #1;
            pop_req = 1'b0;
            if (fq.size() > 0) popped = fq.pop_front();
            fifo_drive();
        end
    end

    // Frame model: packets actually popped in the current frame.
    bit         mon_en       = 1'b0;
    bit         frame_active = 1'b0;
    int         tick_edge    = 0;
    int         npop         = 0;
    logic [7:0] fl[$];
    bit         range_model  = 1'b0;
    logic [3:0] shown_class  = 4'd0;
    bit         prev_rinc    = 1'b0;
    logic [NO-1:0] m_vec;
    int         m_cnt;
    int         m_cls;

    function automatic void eval_frame();
        bit seen[NO];
        int votes[NC];
        for (int i = 0; i < NO; i++) seen[i] = 1'b0;
        for (int c = 0; c < NC; c++) votes[c] = 0;
        m_vec = '0;
        m_cnt = 0;
        foreach (fl[i]) begin
            int p;
            p = int'(fl[i]);
            if (p < NO && !seen[p]) begin
                seen[p] = 1'b1;
                m_vec[NO-1-p] = 1'b1;
                m_cnt++;
                votes[p / NP]++;
            end
        end
        m_cls = 0;
        for (int c = 1; c < NC; c++) if (votes[c] > votes[m_cls]) m_cls = c;
    endfunction

    // Compare process: checks outputs every cycle against the frame model.
    always @(negedge clk) begin
        int strobe_e;
        bit in_done;
        if (mon_en) begin
            strobe_e = tick_edge + W + 2 * npop + 11;
            in_done  = frame_active && (edge_n >= strobe_e);
            chk("result_valid", result_valid, frame_active && (edge_n == strobe_e));
            chk("busy", busy, frame_active && (edge_n < strobe_e));
            if (in_done) begin
                eval_frame();
                chk("model_spike_vec", spike_vec, m_vec);
                chk("model_count", result_count, m_cnt);
                chk("model_class", result_class, m_cls);
                chk("model_range_error", range_error, range_model);
                shown_class = 4'(m_cls);
            end else begin
                chk("class_hold", result_class, shown_class);
                if (!frame_active) chk("idle_range_error", range_error, range_model);
            end
            chk("rinc_while_empty", packet_out_rinc && packet_out_rempty, 1'b0);
            chk("rinc_back_to_back", packet_out_rinc && prev_rinc, 1'b0);
            prev_rinc = packet_out_rinc;
            if (packet_out_rinc && !packet_out_rempty) begin
                fl.push_back(packet_out);
                npop++;
                if (packet_out >= 8'(NO)) range_model = 1'b1;
                pop_req = 1'b1;
            end
            if (reset) begin
                frame_active = 1'b0;
                fl.delete();
                npop        = 0;
                range_model = 1'b0;
                shown_class = 4'd0;
                prev_rinc   = 1'b0;
            end else if (tick) begin
                frame_active = 1'b1;
                tick_edge    = edge_n + 1;
                fl.delete();
                npop = 0;
            end
        end
    end

    // Called at posedge+2; returns the edge number that samples the tick.
    task automatic pulse_tick(output int te);
        te   = edge_n + 1;
        tick = 1'b1;
        @(posedge clk); #2;
        tick = 1'b0;
    endtask

    task automatic wait_valid(output int got);
        got = -1000;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (result_valid) begin
                got = edge_n;
                break;
            end
        end
    endtask

    task automatic wait_npop(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (npop == n) begin
                hit = 1'b1;
                break;
            end
        end
        chk("wait_npop_timeout", hit, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int te;
        int te2;
        int got;
        logic [NO-1:0] ev;

        reset = 1'b1;
        tick  = 1'b0;
        fifo_drive();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_spike_vec", spike_vec, '0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_class", result_class, 4'd0);
        chk("rst_count", result_count, 8'd0);
        chk("rst_range", range_error, 1'b0);
        chk("rst_rinc", packet_out_rinc, 1'b0);
        chk("rst_busy", busy, 1'b0);
        mon_en = 1'b1;

        // Frame 1: 0, 24, 25, 249.
        fq = '{8'd0, 8'd24, 8'd25, 8'd249};
        fifo_drive();
        pulse_tick(te);
        wait_valid(got);
        chk("f1_latency", got - te, 27);
        ev = '0;
        ev[249] = 1'b1; ev[225] = 1'b1; ev[224] = 1'b1; ev[0] = 1'b1;
        chk("f1_spike_vec", spike_vec, ev);
        chk("f1_count", result_count, 8'd4);
        chk("f1_class", result_class, 4'd0);
        chk("f1_range", range_error, 1'b0);
        chk("f1_pops", npop, 4);
        @(posedge clk); #2;
        chk("f1_single_pulse", result_valid, 1'b0);

        // Frame 2: duplicates and a tie between classes 2 and 5.
        fq = '{8'd30, 8'd30, 8'd55, 8'd56, 8'd130, 8'd131};
        fifo_drive();
        pulse_tick(te);
        wait_valid(got);
        chk("f2_latency", got - te, 31);
        chk("f2_count", result_count, 8'd5);
        chk("f2_class", result_class, 4'd2);
        chk("f2_pops", npop, 6);

        // Frame 3: out-of-range packet in the middle.
        fq = '{8'd3, 8'd250, 8'd4};
        fifo_drive();
        pulse_tick(te);
        wait_valid(got);
        chk("f3_latency", got - te, 25);
        chk("f3_range", range_error, 1'b1);
        chk("f3_count", result_count, 8'd2);
        chk("f3_class", result_class, 4'd0);
        chk("f3_pops", npop, 3);

        // Frame 4: empty FIFO; range_error stays set.
        pulse_tick(te);
        wait_valid(got);
        chk("f4_latency", got - te, 19);
        chk("f4_spike_vec", spike_vec, '0);
        chk("f4_count", result_count, 8'd0);
        chk("f4_class", result_class, 4'd0);
        chk("f4_pops", npop, 0);
        chk("f4_range_sticky", range_error, 1'b1);

        // Frame 5: retick while popping the 4th of 10 packets (one per class).
        fq = '{8'd0, 8'd26, 8'd52, 8'd78, 8'd104, 8'd130, 8'd156, 8'd182, 8'd208, 8'd234};
        fifo_drive();
        pulse_tick(te);
        wait_npop(3);
        @(posedge clk); #2;
        chk("f5_in_pop_rinc", packet_out_rinc, 1'b1);
        pulse_tick(te2);
        chk("f5_clear_spike", spike_vec, '0);
        chk("f5_clear_count", result_count, 8'd0);
        chk("f5_clear_valid", result_valid, 1'b0);
        chk("f5_busy", busy, 1'b1);
        wait_valid(got);
        chk("f5_latency", got - te2, 33);
        chk("f5_count", result_count, 8'd7);
        chk("f5_class", result_class, 4'd3);
        chk("f5_pops", npop, 7);
        chk("f5_fifo_drained", fq.size(), 0);
        chk("f5_range_sticky", range_error, 1'b1);

        // Reset during POP with 5 packets still pending.
        fq = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        fifo_drive();
        pulse_tick(te);
        wait_npop(1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("r_rinc", packet_out_rinc, 1'b0);
        chk("r_spike_vec", spike_vec, '0);
        chk("r_count", result_count, 8'd0);
        chk("r_class", result_class, 4'd0);
        chk("r_valid", result_valid, 1'b0);
        chk("r_range", range_error, 1'b0);
        chk("r_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        chk("r_no_more_pops", fq.size(), 5);
        chk("r_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
